div_8bit_seq: RTL and testbench

Sequential unsigned restoring divider for the 8-bit ALU datapath. It is the inverse-direction companion of the adder/multiplier paths. It accepts a dividend/divisor pair on a start pulse and iterates one quotient bit per clock using a trial subtraction. It returns quotient and remainder with a one-cycle done pulse. It sits beside the combinational adder in the ALU and is selected by the ALU op decoder for DIV/MOD operations.

---
 rtl/alu_pkg.sv | 16 +
 rtl/div_8bit_seq_if.sv | 30 +++
 rtl/div_8bit_seq_trial_sub.sv | 22 ++
 rtl/div_8bit_seq.sv | 127 ++++++++++++
 tb/tb_div_8bit_seq.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU package: datapath width, divider FSM state type and the
// iteration-counter width used by the sequential divider.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 8;

    // Wide enough to hold ALU_WIDTH itself, not just ALU_WIDTH-1.
    localparam int unsigned DIV_CNT_W = $clog2(ALU_WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_8bit_seq_if.sv
// Handshake/result bundle of the sequential divider.
//   start/dividend/divisor : request side, driven by the master
//   busy/done              : status, driven by the divider
//   quotient/remainder/div_by_zero : registered results
interface div_8bit_seq_if
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/div_8bit_seq_trial_sub.sv
// Combinational trial subtractor for the restoring divider.
//   a_i, b_i : unsigned operands (W bits)
//   diff_o   : low W bits of a_i - b_i
//   borrow_o : set when a_i < b_i; {borrow_o, diff_o} is the W+1-bit
//              difference of the zero-extended operands
module trial_sub #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] diff_o,
    output logic         borrow_o
);

    logic [W:0] sum;

    // {0,a} + ~{0,b} + 1; the top bit is the sign of the W+1-bit result.
    assign sum      = {1'b0, a_i} + {1'b1, ~b_i} + {{W{1'b0}}, 1'b1};
    assign diff_o   = sum[W-1:0];
    assign borrow_o = sum[W];

endmodule

// File: rtl/div_8bit_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   div_if   : slave side of div_8bit_seq_if (start/operands in,
//              busy/done/quotient/remainder/div_by_zero out)
// A zero divisor skips CALC and reports quotient=all-ones,
// remainder=dividend, div_by_zero=1.
module div_8bit_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    div_8bit_seq_if.slave div_if
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_t       state_q, state_d;
    // Partial remainder is provably < 2^(WIDTH-1) before every shift, so
    // only WIDTH-1 bits are stored; the full-width final value goes
    // straight into remainder_q.
    logic [WIDTH-2:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] rem_sh;
    logic [WIDTH-1:0] trial_diff;
    logic             trial_borrow;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    // {rem, quo_sh} << 1: quotient MSB moves into the remainder LSB.
    assign rem_sh = {rem_q, quo_q[WIDTH-1]};

    trial_sub #(.W(WIDTH)) u_trial_sub (
        .a_i      (rem_sh),
        .b_i      (dvs_q),
        .diff_o   (trial_diff),
        .borrow_o (trial_borrow)
    );

    // Negative trial restores the shifted remainder and shifts in a 0.
    assign rem_next = trial_borrow ? rem_sh : trial_diff;
    assign quo_next = {quo_q[WIDTH-2:0], ~trial_borrow};

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            IDLE: begin
                if (div_if.start) begin
                    if (div_if.divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = div_if.dividend;
                        dbz_d       = 1'b1;
                        state_d     = DONE;
                    end else begin
                        rem_d   = '0;
                        quo_d   = div_if.dividend;
                        dvs_d   = div_if.divisor;
                        cnt_d   = '0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = rem_next[WIDTH-2:0];
                quo_d = quo_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    quotient_d  = quo_next;
                    remainder_d = rem_next;
                    dbz_d       = 1'b0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign div_if.busy        = (state_q == CALC);
    assign div_if.done        = (state_q == DONE);
    assign div_if.quotient    = quotient_q;
    assign div_if.remainder   = remainder_q;
    assign div_if.div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_8bit_seq.sv
// Self-checking bench for div_8bit_seq: directed vector table, hand-written
// multi-cycle sequences and a randomized sweep against an arithmetic model.
module tb_div_8bit_seq;
    import alu_pkg::*;

    localparam int unsigned W     = ALU_WIDTH;
    localparam int          ALL1  = (1 << W) - 1;
    localparam int          NRAND = 2000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    div_8bit_seq_if #(.WIDTH(W)) div_if ();

    div_8bit_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .div_if (div_if)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        int z;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer division, divide-by-zero convention.
    function automatic void ref_div(input int a, input int b,
                                    output int q, output int r, output int z);
        if (b == 0) begin
            q = ALL1;
            r = a;
            z = 1;
        end else begin
            q = a / b;
            r = a % b;
            z = 0;
        end
    endfunction

    // Called at a negedge with the divider idle. Returns results sampled at
    // the done cycle, the done latency in cycles after the start edge (-1 on
    // timeout), busy cycles seen, whether done was still high one cycle
    // later, and how often results moved before done. Ends one negedge after
    // done, i.e. with the divider back in IDLE.
    task automatic run(input int a, input int b,
                       output int q, output int r, output int z,
                       output int lat, output int busy_n,
                       output int done_after, output int hold_bad);
        int hq, hr, hz;
        hq = int'(div_if.quotient);
        hr = int'(div_if.remainder);
        hz = int'(div_if.div_by_zero);
        div_if.start    = 1'b1;
        div_if.dividend = W'(a);
        div_if.divisor  = W'(b);
        @(posedge clk);
        #1;
        div_if.start    = 1'b0;
        div_if.dividend = W'($urandom);
        div_if.divisor  = W'($urandom);
        lat      = -1;
        busy_n   = 0;
        hold_bad = 0;
        q = -1; r = -1; z = -1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (div_if.busy) busy_n++;
            if (div_if.done) begin
                lat = n;
                q = int'(div_if.quotient);
                r = int'(div_if.remainder);
                z = int'(div_if.div_by_zero);
                break;
            end
            if (int'(div_if.quotient) != hq || int'(div_if.remainder) != hr ||
                int'(div_if.div_by_zero) != hz)
                hold_bad++;
        end
        @(negedge clk);
        done_after = int'(div_if.done);
    endtask

    initial begin
        int q, r, z, lat, busy_n, done_after, hold_bad;
        int eq, er, ez, a, b, cnt, bcnt;

        vecs[0]  = '{a: 200, b: 7,   q: 28,  r: 4,  z: 0};
        vecs[1]  = '{a: 255, b: 1,   q: 255, r: 0,  z: 0};
        vecs[2]  = '{a: 5,   b: 9,   q: 0,   r: 5,  z: 0};
        vecs[3]  = '{a: 90,  b: 0,   q: 255, r: 90, z: 1};
        vecs[4]  = '{a: 100, b: 3,   q: 33,  r: 1,  z: 0};
        vecs[5]  = '{a: 9,   b: 2,   q: 4,   r: 1,  z: 0};
        vecs[6]  = '{a: 255, b: 255, q: 1,   r: 0,  z: 0};
        vecs[7]  = '{a: 0,   b: 1,   q: 0,   r: 0,  z: 0};
        vecs[8]  = '{a: 254, b: 128, q: 1,   r: 126, z: 0};
        vecs[9]  = '{a: 1,   b: 255, q: 0,   r: 1,  z: 0};
        vecs[10] = '{a: 128, b: 2,   q: 64,  r: 0,  z: 0};
        vecs[11] = '{a: 0,   b: 0,   q: 255, r: 0,  z: 1};

        div_if.start    = 1'b0;
        div_if.dividend = '0;
        div_if.divisor  = '0;

        // Reset values
        repeat (2) @(negedge clk);
        check("reset busy",      int'(div_if.busy), 0);
        check("reset done",      int'(div_if.done), 0);
        check("reset quotient",  int'(div_if.quotient), 0);
        check("reset remainder", int'(div_if.remainder), 0);
        check("reset dbz",       int'(div_if.div_by_zero), 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vector table
        foreach (vecs[i]) begin
            run(vecs[i].a, vecs[i].b, q, r, z, lat, busy_n, done_after, hold_bad);
            check($sformatf("vec%0d quotient", i),  q, vecs[i].q);
            check($sformatf("vec%0d remainder", i), r, vecs[i].r);
            check($sformatf("vec%0d dbz", i),       z, vecs[i].z);
            check($sformatf("vec%0d latency", i),   lat, vecs[i].z ? 1 : W + 1);
            check($sformatf("vec%0d busy cycles", i), busy_n, vecs[i].z ? 0 : W);
            check($sformatf("vec%0d done one-shot", i), done_after, 0);
            check($sformatf("vec%0d results held", i), hold_bad, 0);
        end

        // Back-to-back: 255/1 then 5/9 at the first IDLE edge after done
        run(255, 1, q, r, z, lat, busy_n, done_after, hold_bad);
        check("b2b first quotient", q, 255);
        check("b2b first remainder", r, 0);
        run(5, 9, q, r, z, lat, busy_n, done_after, hold_bad);
        check("b2b second held 255/0", hold_bad, 0);
        check("b2b second quotient", q, 0);
        check("b2b second remainder", r, 5);
        check("b2b second latency", lat, W + 1);

        // start ignored mid-CALC with changed operands
        div_if.start    = 1'b1;
        div_if.dividend = W'(100);
        div_if.divisor  = W'(3);
        @(posedge clk);
        #1;
        div_if.start = 1'b0;
        cnt = 0; lat = -1; bcnt = 0; q = -1; r = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 2) begin
                div_if.start    = 1'b1;
                div_if.dividend = W'(50);
                div_if.divisor  = W'(5);
            end
            if (n == 5) div_if.start = 1'b0;
            if (div_if.busy) bcnt++;
            if (div_if.done) begin
                cnt++;
                if (lat < 0) begin
                    lat = n;
                    q = int'(div_if.quotient);
                    r = int'(div_if.remainder);
                end
            end
        end
        check("ignore done pulses", cnt, 1);
        check("ignore latency", lat, W + 1);
        check("ignore quotient", q, 33);
        check("ignore remainder", r, 1);
        check("ignore busy cycles", bcnt, W);

        // Reset pulsed mid-CALC at edge k+4
        div_if.start    = 1'b1;
        div_if.dividend = W'(200);
        div_if.divisor  = W'(7);
        @(posedge clk);
        #1;
        div_if.start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("pre-abort busy", int'(div_if.busy), 1);
        rst = 1'b1;
        #1;
        check("abort busy",      int'(div_if.busy), 0);
        check("abort done",      int'(div_if.done), 0);
        check("abort quotient",  int'(div_if.quotient), 0);
        check("abort remainder", int'(div_if.remainder), 0);
        check("abort dbz",       int'(div_if.div_by_zero), 0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (div_if.done || div_if.busy) cnt++;
        end
        check("abort no activity", cnt, 0);
        run(9, 2, q, r, z, lat, busy_n, done_after, hold_bad);
        check("post-abort quotient", q, 4);
        check("post-abort remainder", r, 1);
        check("post-abort latency", lat, W + 1);

        // Random sweep against the arithmetic model
        for (int i = 0; i < NRAND; i++) begin
            a = int'($urandom_range(0, ALL1));
            b = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(0, ALL1));
            ref_div(a, b, eq, er, ez);
            run(a, b, q, r, z, lat, busy_n, done_after, hold_bad);
            check($sformatf("rand %0d/%0d quotient", a, b), q, eq);
            check($sformatf("rand %0d/%0d remainder", a, b), r, er);
            check($sformatf("rand %0d/%0d dbz", a, b), z, ez);
            check($sformatf("rand %0d/%0d latency", a, b), lat, (b == 0) ? 1 : W + 1);
            if (b != 0) begin
                check($sformatf("rand %0d/%0d identity", a, b), q * b + r, a);
                check($sformatf("rand %0d/%0d r<d", a, b), int'(r < b), 1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
